// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared sparse-map constants and FSM state encoding
package sm_pkg;
  localparam int GROUP   = 16;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int BURST_W = 5;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    REQ_SM,
    WR_SM,
    REQ_NZ,
    WR_NZ
  } state_t;
endpackage

// File: rtl/sm_encoder_if.sv
// rtl/sm_encoder_if.sv - pixel input stream and pixel-memory write port
interface sm_encoder_if;
  import sm_pkg::*;

  logic              px_VLD;
  logic              px_RDY;
  logic [DATA_W-1:0] px_value_in;
  logic              px_last;

  logic               pxMem_WR_REQ;
  logic               pxMem_GRANT;
  logic               pxMem_WR_VLD;
  logic               pxMem_WR_RDY;
  logic [ADDR_W-1:0]  pxMem_Addr;
  logic [BURST_W-1:0] px_burst;
  logic [DATA_W-1:0]  pxMem_out;

  modport master (
    input  px_VLD, px_value_in, px_last, pxMem_GRANT, pxMem_WR_RDY,
    output px_RDY, pxMem_WR_REQ, pxMem_WR_VLD, pxMem_Addr, px_burst, pxMem_out
  );

  modport slave (
    output px_VLD, px_value_in, px_last, pxMem_GRANT, pxMem_WR_RDY,
    input  px_RDY, pxMem_WR_REQ, pxMem_WR_VLD, pxMem_Addr, px_burst, pxMem_out
  );
endinterface

// File: rtl/sm_nz_buffer.sv
// rtl/sm_nz_buffer.sv - nonzero value store for one group, appended at nnz
module sm_nz_buffer import sm_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  nnz
);
  logic [DATA_W-1:0] mem [GROUP];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nnz <= '0;
    end else if (clr) begin
      nnz <= '0;
    end else if (wr_en) begin
      nnz <= nnz + CNT_W'(1);
    end
  end

  // Storage needs no reset: only entries below nnz are ever read out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[nnz[IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/sm_encoder.sv
// rtl/sm_encoder.sv - packs 16-pixel groups into SM word + nonzero list bursts
module sm_encoder import sm_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] start_address,
  input  logic              op_start,
  output logic              busy,
  output logic [ADDR_W-1:0] end_address,
  sm_encoder_if.master      bus
);
  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  wr_addr;
  logic [GROUP-1:0]   sm;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               last_grp;
  logic               px_fire, beat, nz_last, group_done, clr;
  logic [CNT_W-1:0]   nnz;
  logic [DATA_W-1:0]  nz_data;

  assign px_fire = (state == COLLECT) && bus.px_VLD;
  assign beat    = bus.pxMem_WR_VLD && bus.pxMem_WR_RDY;
  assign nz_last = ({1'b0, rd_idx} == (nnz - CNT_W'(1)));
  assign busy    = (state != IDLE);
  assign clr     = (state == IDLE) || group_done;

  sm_nz_buffer u_nz_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (px_fire && (bus.px_value_in != '0)),
    .wr_data (bus.px_value_in),
    .rd_idx  (rd_idx),
    .rd_data (nz_data),
    .nnz     (nnz)
  );

  always_comb begin
    state_nxt  = state;
    group_done = 1'b0;
    case (state)
      IDLE:    if (op_start) state_nxt = COLLECT;
      COLLECT: if (px_fire && (idx == IDX_W'(GROUP - 1) || bus.px_last)) state_nxt = REQ_SM;
      REQ_SM:  if (bus.pxMem_GRANT) state_nxt = WR_SM;
      WR_SM: begin
        if (beat) begin
          if (nnz == '0) begin
            group_done = 1'b1;
            state_nxt  = last_grp ? IDLE : COLLECT;
          end else begin
            state_nxt = REQ_NZ;
          end
        end
      end
      REQ_NZ:  if (bus.pxMem_GRANT) state_nxt = WR_NZ;
      WR_NZ: begin
        if (beat && nz_last) begin
          group_done = 1'b1;
          state_nxt  = last_grp ? IDLE : COLLECT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.px_RDY       = (state == COLLECT);
    bus.pxMem_WR_REQ = 1'b0;
    bus.pxMem_WR_VLD = 1'b0;
    bus.pxMem_Addr   = '0;
    bus.px_burst     = '0;
    bus.pxMem_out    = '0;
    case (state)
      REQ_SM: begin
        bus.pxMem_WR_REQ = 1'b1;
        bus.px_burst     = BURST_W'(1);
      end
      WR_SM: begin
        bus.pxMem_WR_REQ = 1'b1;
        bus.pxMem_WR_VLD = 1'b1;
        bus.pxMem_Addr   = wr_addr;
        bus.px_burst     = BURST_W'(1);
        bus.pxMem_out    = sm;
      end
      REQ_NZ: begin
        bus.pxMem_WR_REQ = 1'b1;
        bus.px_burst     = nnz;
      end
      WR_NZ: begin
        bus.pxMem_WR_REQ = 1'b1;
        bus.pxMem_WR_VLD = 1'b1;
        bus.pxMem_Addr   = wr_addr;
        bus.px_burst     = nnz;
        bus.pxMem_out    = nz_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_addr     <= '0;
      sm          <= '0;
      idx         <= '0;
      rd_idx      <= '0;
      last_grp    <= 1'b0;
      end_address <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && op_start) begin
        wr_addr <= start_address;
      end else if (beat) begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end
      if (clr) begin
        sm       <= '0;
        idx      <= '0;
        last_grp <= 1'b0;
      end else if (px_fire) begin
        sm[idx]  <= (bus.px_value_in != '0);
        idx      <= idx + IDX_W'(1);
        last_grp <= bus.px_last;
      end
      if (state == REQ_NZ) begin
        rd_idx <= '0;
      end else if (state == WR_NZ && beat) begin
        rd_idx <= rd_idx + IDX_W'(1);
      end
      // Leaving for IDLE always coincides with a final beat, so the address has one more step.
      if (state != IDLE && state_nxt == IDLE) begin
        end_address <= wr_addr + ADDR_W'(1);
      end
    end
  end
endmodule
